// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation codes,
// FSM states and the iteration-counter width.
package muldiv_pkg;

    localparam int DATA_W = 32;
    localparam int ITER_W = $clog2(DATA_W) + 1;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers.
// Shift-add multiply and restoring divide share one accumulator and counter.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [WIDTH-1:0]   ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W  = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ITER_W-1:0]  LAST_IT = ITER_W'(WIDTH - 1);

    state_t            state_r;
    logic [ITER_W-1:0] cnt_r;
    logic [1:0]        op_r;
    logic              neg_res_r;
    logic              neg_rem_r;
    logic [WIDTH-1:0]  dvsr_r;
    logic [WIDTH-1:0]  acc_r;
    logic [WIDTH-1:0]  low_r;

    logic              is_div_s;
    logic              start_div_s;
    logic              start_signed_s;
    logic [WIDTH-1:0]  a_mag_s;
    logic [WIDTH-1:0]  b_mag_s;
    logic [WIDTH:0]    sum_s;
    logic [WIDTH:0]    rem_sh_s;
    logic [WIDTH:0]    diff_s;
    logic [WIDTH-1:0]  acc_nx_s;
    logic [WIDTH-1:0]  low_nx_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]  quot_s;
    logic [WIDTH-1:0]  rem_s;
    logic [WIDTH-1:0]  hi_fin_s;
    logic [WIDTH-1:0]  lo_fin_s;

    // Unsigned magnitude; the most negative value maps to 2^(WIDTH-1) unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
        if (sgn && x[WIDTH-1]) begin
            magnitude = (~x) + ONE_W;
        end else begin
            magnitude = x;
        end
    endfunction

    // Decode of the incoming request and operand magnitudes.
    always_comb begin
        start_div_s    = (op == OP_DIV) || (op == OP_DIVU);
        start_signed_s = (op == OP_MULT) || (op == OP_DIV);
        a_mag_s        = magnitude(a, start_signed_s);
        b_mag_s        = magnitude(b, start_signed_s);
    end

    // One multiply or divide iteration on the shared {acc, low} pair.
    always_comb begin
        is_div_s = (op_r == OP_DIV) || (op_r == OP_DIVU);
        sum_s    = {1'b0, acc_r} + (low_r[0] ? {1'b0, dvsr_r} : {(WIDTH+1){1'b0}});
        rem_sh_s = {acc_r, low_r[WIDTH-1]};
        diff_s   = rem_sh_s - {1'b0, dvsr_r};
        if (is_div_s) begin
            // diff_s[WIDTH] is the borrow: set means the trial subtract failed
            if (diff_s[WIDTH] == 1'b0) begin
                acc_nx_s = diff_s[WIDTH-1:0];
                low_nx_s = {low_r[WIDTH-2:0], 1'b1};
            end else begin
                acc_nx_s = rem_sh_s[WIDTH-1:0];
                low_nx_s = {low_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_nx_s = sum_s[WIDTH:1];
            low_nx_s = {sum_s[0], low_r[WIDTH-1:1]};
        end
    end

    // Sign fix-up and HI/LO placement for the final iteration.
    always_comb begin
        prod_s = {acc_nx_s, low_nx_s};
        if ((op_r == OP_MULT) && neg_res_r) begin
            prod_s = (~prod_s) + ONE_2W;
        end else begin
            prod_s = {acc_nx_s, low_nx_s};
        end
        quot_s = neg_res_r ? ((~low_nx_s) + ONE_W) : low_nx_s;
        rem_s  = neg_rem_r ? ((~acc_nx_s) + ONE_W) : acc_nx_s;
        if (is_div_s) begin
            hi_fin_s = rem_s;
            lo_fin_s = quot_s;
        end else begin
            hi_fin_s = prod_s[2*WIDTH-1:WIDTH];
            lo_fin_s = prod_s[WIDTH-1:0];
        end
    end

    // Control FSM, iteration datapath registers and architectural outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= {ITER_W{1'b0}};
            op_r        <= OP_MULT;
            neg_res_r   <= 1'b0;
            neg_rem_r   <= 1'b0;
            dvsr_r      <= {WIDTH{1'b0}};
            acc_r       <= {WIDTH{1'b0}};
            low_r       <= {WIDTH{1'b0}};
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= {WIDTH{1'b0}};
            lo          <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start && start_div_s && (b == {WIDTH{1'b0}})) begin
                        // Divide by zero skips CALC entirely
                        state_r     <= DONE;
                        op_r        <= op;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        div_by_zero <= 1'b1;
                        hi          <= a;
                        lo          <= {WIDTH{1'b1}};
                    end else if (start) begin
                        state_r     <= CALC;
                        cnt_r       <= {ITER_W{1'b0}};
                        op_r        <= op;
                        neg_res_r   <= start_signed_s && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_rem_r   <= start_signed_s && a[WIDTH-1];
                        dvsr_r      <= start_div_s ? b_mag_s : a_mag_s;
                        low_r       <= start_div_s ? a_mag_s : b_mag_s;
                        acc_r       <= {WIDTH{1'b0}};
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        div_by_zero <= 1'b0;
                    end else begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                    end
                end
                CALC: begin
                    acc_r <= acc_nx_s;
                    low_r <= low_nx_s;
                    if (cnt_r == LAST_IT) begin
                        state_r <= DONE;
                        cnt_r   <= {ITER_W{1'b0}};
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        hi      <= hi_fin_s;
                        lo      <= lo_fin_s;
                    end else begin
                        cnt_r <= cnt_r + {{(ITER_W-1){1'b0}}, 1'b1};
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= {ITER_W{1'b0}};
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed table, random ops against a
// plain-arithmetic reference model, and hand-written multi-cycle sequences.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;
    logic        prev_busy = 1'b0;
    logic [31:0] prev_hi, prev_lo;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } vec_t;

    vec_t tbl[6];

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: MIPS results from plain 64-bit arithmetic
    function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] eh, output logic [31:0] el, output logic ez);
        longint      sp, sq, sr;
        logic [63:0] up;
        ez = 1'b0;
        case (o)
            OP_MULT: begin
                sp = longint'($signed(x)) * longint'($signed(y));
                eh = sp[63:32]; el = sp[31:0];
            end
            OP_MULTU: begin
                up = {32'h0, x} * {32'h0, y};
                eh = up[63:32]; el = up[31:0];
            end
            default: begin
                if (y == 32'h0) begin
                    eh = x; el = 32'hFFFF_FFFF; ez = 1'b1;
                end else if (o == OP_DIV) begin
                    sq = longint'($signed(x)) / longint'($signed(y));
                    sr = longint'($signed(x)) % longint'($signed(y));
                    eh = sr[31:0]; el = sq[31:0];
                end else begin
                    eh = x % y; el = x / y;
                end
            end
        endcase
    endfunction

    // Issue one op (optionally in the current cycle) and wait for done, bounded.
    task automatic do_op(input bit now, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int lat, output logic first_busy);
        if (!now) @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        first_busy = busy;
        lat = 1;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Protocol monitor: busy/done exclusive, HI/LO frozen while busy.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (busy && done) begin
                errors++;
                $display("FAIL busy_done_overlap: got busy=1 done=1 expected not both");
            end else if (busy && prev_busy && (hi !== prev_hi || lo !== prev_lo)) begin
                errors++;
                $display("FAIL hilo_stable: got %h_%h expected %h_%h", hi, lo, prev_hi, prev_lo);
            end
            prev_busy = busy;
            prev_hi   = hi;
            prev_lo   = lo;
        end
    end

    initial begin
        int          lat;
        logic        fb;
        logic [31:0] eh, el;
        logic        ez;
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        bit          seen_done;

        tbl[0] = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
        tbl[1] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        tbl[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        tbl[3] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        tbl[4] = '{OP_DIVU,  32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1};
        tbl[5] = '{OP_DIVU,  32'h0000_03E8, 32'h0000_0007, 32'h0000_0006, 32'h0000_008E, 1'b0};

        rst_n = 1'b0; start = 1'b0; op = 2'b00; a = 32'h0; b = 32'h0;
        repeat (2) @(negedge clk);
        check("reset_busy", {63'h0, busy}, 64'h0);
        check("reset_done", {63'h0, done}, 64'h0);
        check("reset_dbz",  {63'h0, div_by_zero}, 64'h0);
        check("reset_hilo", {hi, lo}, 64'h0);
        rst_n = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < 6; i++) begin
            do_op(1'b0, tbl[i].op, tbl[i].a, tbl[i].b, lat, fb);
            check($sformatf("tbl%0d_latency", i), 64'(lat), tbl[i].dbz ? 64'd1 : 64'd33);
            check($sformatf("tbl%0d_hilo", i), {hi, lo}, {tbl[i].hi, tbl[i].lo});
            check($sformatf("tbl%0d_dbz", i), {63'h0, div_by_zero}, {63'h0, tbl[i].dbz});
            if (tbl[i].dbz) begin
                repeat (3) @(negedge clk);
                check("dbz_sticky", {63'h0, div_by_zero}, 64'h1);
                op = OP_MULTU; a = 32'h3; b = 32'h3; start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                check("dbz_cleared", {63'h0, div_by_zero}, 64'h0);
                lat = 1;
                while (!done && lat < 100) begin @(negedge clk); lat++; end
                check("after_dbz_lo", {32'h0, lo}, 64'd9);
            end
        end

        // Random operations against the reference model
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : 32'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 32'h0 : 32'($urandom);
            if (i % 5 == 1) rb = 32'($urandom_range(1, 20));
            if (i % 7 == 2) rb = 32'hFFFF_FFFF;
            model(ro, ra, rb, eh, el, ez);
            do_op(1'b0, ro, ra, rb, lat, fb);
            check($sformatf("rnd%0d_op%0d_%h_%h", i, ro, ra, rb), {hi, lo, 31'h0, div_by_zero, 32'(lat)},
                  {eh, el, 31'h0, ez, (ez ? 32'd1 : 32'd33)});
        end

        // start during CALC is ignored; start in DONE begins the next op at once
        @(negedge clk);
        op = OP_MULTU; a = 32'd7; b = 32'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0; lat = 1;
        repeat (9) begin @(negedge clk); lat++; end
        op = OP_MULT; a = 32'h1; b = 32'h1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; lat++;
        check("ignored_start_busy", {63'h0, busy}, 64'h1);
        while (!done && lat < 100) begin @(negedge clk); lat++; end
        check("ignored_start_latency", 64'(lat), 64'd33);
        check("ignored_start_hilo", {hi, lo}, {32'h0, 32'd42});
        do_op(1'b1, OP_DIVU, 32'd100, 32'd7, lat, fb);
        check("b2b_busy", {63'h0, fb}, 64'h1);
        check("b2b_latency", 64'(lat), 64'd33);
        check("b2b_hilo", {hi, lo}, {32'd2, 32'd14});

        // Reset in the middle of a divide
        @(negedge clk);
        op = OP_DIVU; a = 32'd1000; b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (13) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_busy", {63'h0, busy}, 64'h0);
        check("midrst_hilo", {hi, lo}, 64'h0);
        seen_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        check("midrst_no_done", {63'h0, seen_done}, 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the MIPS execute stage, alongside the ALU. Takes the same two register operands, runs MULT/MULTU/DIV/DIVU over multiple cycles and holds the results in architectural HI/LO registers. The control unit stalls on `busy`, and the write-back mux reads `hi`/`lo` for MFHI/MFLO. The 64-bit result is built with a shift-add multiply and a restoring divide, one bit per cycle.

## Interface
- `WIDTH`, 32, operand width; HI and LO are each `WIDTH` bits.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  request; sampled only when the unit can accept.
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`  in  WIDTH  rs operand (multiplicand / dividend).
- `b`  in  WIDTH  rt operand (multiplier / divisor).
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse; HI/LO are valid from this cycle.
- `div_by_zero`  out  1  sticky until next accepted start; set by DIV/DIVU with `b`=0.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- States:
  - IDLE: `busy`=0, `done`=0.
  - CALC: `busy`=1. A 6-bit iteration counter runs 0..WIDTH-1.
  - DONE: `busy`=0, `done`=1.
- Accept:
  - A start is accepted when the state is IDLE or DONE and `start`=1. This allows back-to-back operations with no idle cycle.
  - On accept, `a`, `b` and `op` are latched. `a` and `b` are latched as magnitudes for signed ops, together with the result-sign bits. `div_by_zero` is cleared.
  - `start` while in CALC is ignored; it is neither queued nor an error.
- Multiply:
  - 2·WIDTH-bit accumulator. Each CALC cycle: if the multiplier LSB is 1, add the multiplicand to the upper half. Then shift the {acc, multiplier} pair right by 1.
  - For MULT, the product is two's-complement negated at the end if exactly one operand was negative.
- Divide:
  - Restoring divide. Each CALC cycle: shift {rem, quot} left by 1 and trial-subtract the divisor from rem. Keep the difference and set the quotient LSB to 1 if it is non-negative.
  - For DIV, the quotient is negated if the operand signs differ. The remainder takes the sign of the dividend.
  - −2^31 / −1 produces LO=0x80000000 and HI=0 with no special case.
- Result placement: MULT/MULTU write HI=upper word, LO=lower word. DIV/DIVU write LO=quotient, HI=remainder.
- Divide by zero: CALC is skipped and the unit goes straight to DONE. Results are LO=0xFFFFFFFF, HI=`a` (raw dividend), `div_by_zero`=1.
- HI/LO change only on the entry edge into DONE. They hold indefinitely otherwise.
- Width rules:
  - Magnitude of −2^31 is 2^31, held unsigned in `WIDTH` bits.
  - The multiply add uses a WIDTH+1-bit sum to keep the carry.
  - The trial subtract uses WIDTH+1 bits; the sign bit is the borrow.

## Timing
- Start accepted at edge k:
  - CALC for edges k+1..k+WIDTH (32 iterations).
  - The final iteration and sign fix are registered into HI/LO at edge k+WIDTH, entering DONE.
  - `done`=1 during the cycle after edge k+WIDTH.
  - Latency start-to-done is 33 cycles for WIDTH=32.
- Divide by zero: `done` is high in the cycle after edge k; latency is 1.
- DONE lasts exactly one cycle unless a new start is accepted in it. In that case the next state is CALC, and `done` still pulses for that one cycle.
- Reset values: state IDLE, counter 0, `busy`=0, `done`=0, `div_by_zero`=0, `hi`=0, `lo`=0.
- Reset mid-CALC aborts the operation at that edge. No `done` is produced and HI/LO return to 0.
- `busy` and `done` are never high together. `hi`/`lo` are stable whenever `busy`=1.

## Structure
- Shared package `muldiv_pkg` holds:
  - the `op` encoding constants (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU);
  - the state enum (IDLE, CALC, DONE);
  - ITER_W = $clog2(WIDTH)+1.
- Single module. No sub-module is natural, because the multiply and divide iterations share the accumulator/remainder register and the counter.

## Test plan
- MULT a=0xFFFFFFFD (−3), b=5 -> `done` after 33 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- MULTU a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV a=0xFFFFFFF9 (−7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU a=100, b=0 -> `done` one cycle after start, `div_by_zero`=1, LO=0xFFFFFFFF, HI=100. Next accepted start clears `div_by_zero`.
- Pulse `start` again at cycle 10 of a MULTU 7×6 -> start ignored; HI=0, LO=42 at cycle 33. A new start in the DONE cycle begins the next operation immediately.
- Drive `rst_n`=0 for one edge at cycle 15 of DIVU 1000/7 -> `busy`=0, `hi`/`lo`=0 next cycle, and no `done` pulse ever appears for that operation.
